// File: rtl/stage_d_pkg.sv
// Shared definitions for the decode stage: MIPS-I opcode constants, instruction
// field positions, the register index type and the destination-register decode.
package stage_d_pkg;

    typedef logic [4:0] reg_idx_t;

    // Instruction field bit positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int FN_MSB  = 5;
    localparam int FN_LSB  = 0;

    // Opcode constants and ranges
    localparam logic [5:0] OP_SPECIAL    = 6'd0;
    localparam logic [5:0] OP_JAL        = 6'd3;
    localparam logic [5:0] OP_ALUI_FIRST = 6'd8;
    localparam logic [5:0] OP_ALUI_LAST  = 6'd15;
    localparam logic [5:0] OP_MEM_FIRST  = 6'd32;
    localparam logic [5:0] OP_MEM_LAST   = 6'd39;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_RA   = 5'd31;

    // Destination register of an instruction; REG_ZERO means "writes nothing".
    function automatic reg_idx_t decode_wbr(input logic [31:0] instr);
        logic [5:0] opc;
        reg_idx_t   wbr;
        opc = instr[OPC_MSB:OPC_LSB];
        wbr = REG_ZERO;
        if (opc == OP_SPECIAL) begin
            wbr = instr[RD_MSB:RD_LSB];
        end else if (opc == OP_JAL) begin
            wbr = REG_RA;
        end else if ((opc >= OP_ALUI_FIRST && opc <= OP_ALUI_LAST) ||
                     (opc >= OP_MEM_FIRST && opc <= OP_MEM_LAST)) begin
            wbr = instr[RT_MSB:RT_LSB];
        end
        return wbr;
    endfunction

endpackage

// File: rtl/stage_d_if.sv
// Signal bundle around the decode stage: fetch input, forwarding sources from
// X/M/WB, control, and the decoded outputs.
//
// Handshake: i_valid qualifies i_instr/i_pc/i_npc in the cycle they are
// presented. D accepts them on a clock edge only when neither stall nor
// d_hazzard is high; d_hazzard is the fetch stage's stall (an inverted ready),
// so fetch must keep i_* stable while it is asserted. d_valid qualifies every
// d_* output; flush drops the instruction in D regardless of the other inputs.
interface stage_d_if;
    import stage_d_pkg::*;

    logic        stall;
    logic        flush;
    logic        i_valid;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic [31:0] i_npc;
    logic        x_valid;
    reg_idx_t    x_wbr;
    logic [31:0] x_res;
    logic        x_is_load;
    logic        m_valid;
    reg_idx_t    m_wbr;
    logic [31:0] m_res;
    logic        wb_valid;
    reg_idx_t    wb_wbr;
    logic [31:0] wb_res;
    logic        d_valid;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_npc;
    logic [5:0]  d_opcode;
    logic [5:0]  d_fn;
    reg_idx_t    d_rs;
    reg_idx_t    d_rt;
    reg_idx_t    d_wbr;
    logic [31:0] d_simm;
    logic [31:0] d_op1;
    logic [31:0] d_op2;
    logic        d_hazzard;

    modport master (
        output stall, flush, i_valid, i_instr, i_pc, i_npc,
        output x_valid, x_wbr, x_res, x_is_load, m_valid, m_wbr, m_res,
        output wb_valid, wb_wbr, wb_res,
        input  d_valid, d_instr, d_pc, d_npc, d_opcode, d_fn, d_rs, d_rt,
        input  d_wbr, d_simm, d_op1, d_op2, d_hazzard
    );

    modport slave (
        input  stall, flush, i_valid, i_instr, i_pc, i_npc,
        input  x_valid, x_wbr, x_res, x_is_load, m_valid, m_wbr, m_res,
        input  wb_valid, wb_wbr, wb_res,
        output d_valid, d_instr, d_pc, d_npc, d_opcode, d_fn, d_rs, d_rt,
        output d_wbr, d_simm, d_op1, d_op2, d_hazzard
    );

endinterface

// File: rtl/stage_d_regfile.sv
// 32x32 register file, two synchronous read ports (one RAM copy each) and one
// write port. The read address follows the incoming instruction while D loads
// and the held D fields otherwise, so a held instruction re-reads every cycle.
// Read-during-write returns the old contents; $0 always reads as zero.
module stage_d_regfile
    import stage_d_pkg::*;
#(
    parameter bit REGS_INIT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rd_from_i,
    input  reg_idx_t    i_rs,
    input  reg_idx_t    i_rt,
    input  reg_idx_t    d_rs,
    input  reg_idx_t    d_rt,
    input  logic        wb_valid,
    input  reg_idx_t    wb_wbr,
    input  logic [31:0] wb_res,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);

    reg_idx_t    raddr_a;
    reg_idx_t    raddr_b;
    logic        we;
    logic [31:0] mem_a_rd;
    logic [31:0] mem_b_rd;
    logic [31:0] rdata_a_d, rdata_a_q;
    logic [31:0] rdata_b_d, rdata_b_q;

    // Read address select, write enable and $0 masking
    always_comb begin
        raddr_a   = rd_from_i ? i_rs : d_rs;
        raddr_b   = rd_from_i ? i_rt : d_rt;
        we        = wb_valid && (wb_wbr != REG_ZERO);
        rdata_a_d = (raddr_a == REG_ZERO) ? 32'd0 : mem_a_rd;
        rdata_b_d = (raddr_b == REG_ZERO) ? 32'd0 : mem_b_rd;
    end

    generate
        if (REGS_INIT_ZERO) begin : g_init_zero
            logic [31:0] mem_a [32] = '{default: '0};
            logic [31:0] mem_b [32] = '{default: '0};

            // Write both copies together
            always_ff @(posedge clk) begin
                if (we) begin
                    mem_a[wb_wbr] <= wb_res;
                    mem_b[wb_wbr] <= wb_res;
                end
            end

            assign mem_a_rd = mem_a[raddr_a];
            assign mem_b_rd = mem_b[raddr_b];
        end else begin : g_no_init
            logic [31:0] mem_a [32];
            logic [31:0] mem_b [32];

            // Write both copies together
            always_ff @(posedge clk) begin
                if (we) begin
                    mem_a[wb_wbr] <= wb_res;
                    mem_b[wb_wbr] <= wb_res;
                end
            end

            assign mem_a_rd = mem_a[raddr_a];
            assign mem_b_rd = mem_b[raddr_b];
        end
    endgenerate

    // Registered read data (old data on a same-cycle write)
    always_ff @(posedge clk) begin
        rdata_a_q <= rdata_a_d;
        rdata_b_q <= rdata_b_d;
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: rtl/stage_d.sv
// Decode stage: registers the fetched instruction, extracts MIPS-I fields,
// reads the register file, bypasses operands and raises d_hazzard on RAW.
// Optional macro BYPASS_EN enables the X/M bypass paths; without it the
// stage stalls on any X/M producer match instead.
module stage_d
    import stage_d_pkg::*;
#(
    parameter bit REGS_INIT_ZERO = 1'b1
) (
    input logic      clk,
    input logic      rst,
    stage_d_if.slave bus
);

    logic        valid_d, valid_q;
    logic [31:0] instr_d, instr_q;
    logic [31:0] pc_d, pc_q;
    logic [31:0] npc_d, npc_q;
    reg_idx_t    wbr_d, wbr_q;
    reg_idx_t    rs_q, rt_q;
    logic        hazard;
    logic        held;
    logic        rd_from_i;
    logic        x_hit;
    logic [31:0] ram_a, ram_b;
    logic [31:0] op1, op2;

    assign rs_q = instr_q[RS_MSB:RS_LSB];
    assign rt_q = instr_q[RT_MSB:RT_LSB];

    // Operand bypass: $0, then X, M, WB, then the registered RAM value
    function automatic logic [31:0] fwd(input reg_idx_t r, input logic [31:0] ram);
        logic [31:0] v;
        v = ram;
        if (r == REG_ZERO) begin
            v = 32'd0;
`ifdef BYPASS_EN
        end else if (bus.x_valid && bus.x_wbr == r) begin
            v = bus.x_res;
        end else if (bus.m_valid && bus.m_wbr == r) begin
            v = bus.m_res;
`endif
        end else if (bus.wb_valid && bus.wb_wbr == r) begin
            v = bus.wb_res;
        end
        return v;
    endfunction

`ifdef BYPASS_EN
    // Only an X-stage load can produce a value too late to forward
    always_comb begin
        x_hit  = bus.x_valid && bus.x_wbr != REG_ZERO &&
                 (bus.x_wbr == rs_q || bus.x_wbr == rt_q);
        hazard = valid_q && x_hit && bus.x_is_load;
    end
`else
    logic m_hit;
    logic unused_fwd;
    assign unused_fwd = ^{bus.x_res, bus.m_res, bus.x_is_load};

    // No X/M forwarding: any pending X or M producer of a source must stall
    always_comb begin
        x_hit  = bus.x_valid && bus.x_wbr != REG_ZERO &&
                 (bus.x_wbr == rs_q || bus.x_wbr == rt_q);
        m_hit  = bus.m_valid && bus.m_wbr != REG_ZERO &&
                 (bus.m_wbr == rs_q || bus.m_wbr == rt_q);
        hazard = valid_q && (x_hit || m_hit);
    end
`endif

    // Next D contents: flush beats hold beats load
    always_comb begin
        held      = bus.stall || hazard;
        rd_from_i = !bus.flush && !held;
        valid_d   = valid_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        npc_d     = npc_q;
        wbr_d     = wbr_q;
        if (bus.flush) begin
            valid_d = 1'b0;
            pc_d    = 32'd0;
            npc_d   = 32'd0;
        end else if (!held) begin
            valid_d = bus.i_valid;
            instr_d = bus.i_instr;
            pc_d    = bus.i_pc;
            npc_d   = bus.i_npc;
            wbr_d   = decode_wbr(bus.i_instr);
        end
    end

    // D pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            pc_q    <= 32'd0;
            npc_q   <= 32'd0;
            wbr_q   <= REG_ZERO;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            wbr_q   <= wbr_d;
        end
    end

    stage_d_regfile #(
        .REGS_INIT_ZERO(REGS_INIT_ZERO)
    ) u_regfile (
        .clk      (clk),
        .rd_from_i(rd_from_i),
        .i_rs     (bus.i_instr[RS_MSB:RS_LSB]),
        .i_rt     (bus.i_instr[RT_MSB:RT_LSB]),
        .d_rs     (rs_q),
        .d_rt     (rt_q),
        .wb_valid (bus.wb_valid),
        .wb_wbr   (bus.wb_wbr),
        .wb_res   (bus.wb_res),
        .rdata_a  (ram_a),
        .rdata_b  (ram_b)
    );

    // Bypassed operands
    always_comb begin
        op1 = fwd(rs_q, ram_a);
        op2 = fwd(rt_q, ram_b);
    end

    assign bus.d_valid   = valid_q;
    assign bus.d_instr   = instr_q;
    assign bus.d_pc      = pc_q;
    assign bus.d_npc     = npc_q;
    assign bus.d_opcode  = instr_q[OPC_MSB:OPC_LSB];
    assign bus.d_fn      = instr_q[FN_MSB:FN_LSB];
    assign bus.d_rs      = rs_q;
    assign bus.d_rt      = rt_q;
    assign bus.d_wbr     = wbr_q;
    assign bus.d_simm    = {{16{instr_q[IMM_MSB]}}, instr_q[IMM_MSB:IMM_LSB]};
    assign bus.d_op1     = op1;
    assign bus.d_op2     = op2;
    assign bus.d_hazzard = hazard;

endmodule

// File: tb/tb_stage_d.sv
// Bench for stage_d: decode vector table plus directed bypass / hazard /
// stall / flush / reset sequences. Expectations follow BYPASS_EN if defined.
module tb_stage_d;
    import stage_d_pkg::*;

    localparam logic [31:0] ADD = 32'h0085_1020;  // add $2,$4,$5
    localparam logic [31:0] JAL = 32'h0C00_0040;

    // Clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stage_d_if bus();

    stage_d dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wbr;
        logic [31:0] simm;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    // Scoreboard compare
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_i(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        bus.i_valid = v;
        bus.i_instr = instr;
        bus.i_pc    = pc;
        bus.i_npc   = pc + 32'd4;
    endtask

    task automatic idle_fwd();
        bus.x_valid   = 1'b0;
        bus.x_wbr     = 5'd0;
        bus.x_res     = 32'd0;
        bus.x_is_load = 1'b0;
        bus.m_valid   = 1'b0;
        bus.m_wbr     = 5'd0;
        bus.m_res     = 32'd0;
        bus.wb_valid  = 1'b0;
        bus.wb_wbr    = 5'd0;
        bus.wb_res    = 32'd0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0085_1020, 32'h100, 6'd0,  6'h20, 5'd4,  5'd5, 5'd2,  32'h0000_1020};
        vecs[1]  = '{1'b1, 32'h0C00_0040, 32'h104, 6'd3,  6'h00, 5'd0,  5'd0, 5'd31, 32'h0000_0040};
        vecs[2]  = '{1'b1, 32'h2023_FFFF, 32'h108, 6'd8,  6'h3F, 5'd1,  5'd3, 5'd3,  32'hFFFF_FFFF};
        vecs[3]  = '{1'b1, 32'h34E9_8001, 32'h10C, 6'd13, 6'h01, 5'd7,  5'd9, 5'd9,  32'hFFFF_8001};
        vecs[4]  = '{1'b1, 32'h3C01_ABCD, 32'h110, 6'd15, 6'h0D, 5'd0,  5'd1, 5'd1,  32'hFFFF_ABCD};
        vecs[5]  = '{1'b1, 32'h4000_0000, 32'h114, 6'd16, 6'h00, 5'd0,  5'd0, 5'd0,  32'h0000_0000};
        vecs[6]  = '{1'b1, 32'h8FA8_0010, 32'h118, 6'd35, 6'h10, 5'd29, 5'd8, 5'd8,  32'h0000_0010};
        vecs[7]  = '{1'b1, 32'hAFA8_0010, 32'h11C, 6'd43, 6'h10, 5'd29, 5'd8, 5'd0,  32'h0000_0010};
        vecs[8]  = '{1'b1, 32'h9C46_0000, 32'h120, 6'd39, 6'h00, 5'd2,  5'd6, 5'd6,  32'h0000_0000};
        vecs[9]  = '{1'b1, 32'hA046_0000, 32'h124, 6'd40, 6'h00, 5'd2,  5'd6, 5'd0,  32'h0000_0000};
        vecs[10] = '{1'b1, 32'h1C40_0000, 32'h128, 6'd7,  6'h00, 5'd2,  5'd0, 5'd0,  32'h0000_0000};
        vecs[11] = '{1'b0, 32'h0085_1020, 32'h12C, 6'd0,  6'h20, 5'd4,  5'd5, 5'd2,  32'h0000_1020};

        rst       = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive_i(1'b0, 32'd0, 32'd0);
        idle_fwd();
        tick();
        tick();
        check("rst_valid", 32'(bus.d_valid), 32'd0);
        check("rst_pc", bus.d_pc, 32'd0);
        check("rst_npc", bus.d_npc, 32'd0);
        check("rst_instr", bus.d_instr, 32'd0);
        check("rst_wbr", 32'(bus.d_wbr), 32'd0);
        check("rst_haz", 32'(bus.d_hazzard), 32'd0);
        rst = 1'b0;

        // Decode table; register file is still all-zero
        for (int i = 0; i < 12; i++) begin
            drive_i(vecs[i].v, vecs[i].instr, vecs[i].pc);
            exp_q.push_back(vecs[i].instr);
            tick();
            check($sformatf("v%0d_valid", i), 32'(bus.d_valid), 32'(vecs[i].v));
            check($sformatf("v%0d_instr", i), bus.d_instr, exp_q.pop_front());
            check($sformatf("v%0d_pc", i), bus.d_pc, vecs[i].pc);
            check($sformatf("v%0d_npc", i), bus.d_npc, vecs[i].pc + 32'd4);
            check($sformatf("v%0d_opc", i), 32'(bus.d_opcode), 32'(vecs[i].opc));
            check($sformatf("v%0d_fn", i), 32'(bus.d_fn), 32'(vecs[i].fn));
            check($sformatf("v%0d_rs", i), 32'(bus.d_rs), 32'(vecs[i].rs));
            check($sformatf("v%0d_rt", i), 32'(bus.d_rt), 32'(vecs[i].rt));
            check($sformatf("v%0d_wbr", i), 32'(bus.d_wbr), 32'(vecs[i].wbr));
            check($sformatf("v%0d_simm", i), bus.d_simm, vecs[i].simm);
            check($sformatf("v%0d_op1", i), bus.d_op1, 32'd0);
            check($sformatf("v%0d_op2", i), bus.d_op2, 32'd0);
            check($sformatf("v%0d_haz", i), 32'(bus.d_hazzard), 32'd0);
        end

        // WB write on the edge D loads: RAM returns old data, WB bypass covers it
        bus.wb_valid = 1'b1;
        bus.wb_wbr   = 5'd4;
        bus.wb_res   = 32'h1234;
        drive_i(1'b1, ADD, 32'h200);
        tick();
        check("wb_byp_op1", bus.d_op1, 32'h1234);
        bus.wb_valid = 1'b0;
        tick();
        check("ram_op1", bus.d_op1, 32'h1234);
        check("ram_op2", bus.d_op2, 32'd0);

        // Writes to $0 are discarded and $0 reads zero
        bus.wb_valid = 1'b1;
        bus.wb_wbr   = 5'd0;
        bus.wb_res   = 32'hFFFF;
        drive_i(1'b1, 32'h2003_0000, 32'h208);
        tick();
        check("r0_byp_op1", bus.d_op1, 32'd0);
        bus.wb_valid = 1'b0;
        tick();
        check("r0_ram_op1", bus.d_op1, 32'd0);

        // X has priority over M
        drive_i(1'b1, ADD, 32'h210);
        tick();
        bus.x_valid = 1'b1;
        bus.x_wbr   = 5'd4;
        bus.x_res   = 32'hAAAA;
        bus.m_valid = 1'b1;
        bus.m_wbr   = 5'd4;
        bus.m_res   = 32'hBBBB;
        #1;
`ifdef BYPASS_EN
        check("xm_op1", bus.d_op1, 32'hAAAA);
        check("xm_haz", 32'(bus.d_hazzard), 32'd0);
`else
        check("xm_op1", bus.d_op1, 32'h1234);
        check("xm_haz", 32'(bus.d_hazzard), 32'd1);
`endif
        bus.x_valid = 1'b0;
        #1;
`ifdef BYPASS_EN
        check("m_op1", bus.d_op1, 32'hBBBB);
        check("m_haz", 32'(bus.d_hazzard), 32'd0);
`else
        check("m_op1", bus.d_op1, 32'h1234);
        check("m_haz", 32'(bus.d_hazzard), 32'd1);
`endif
        bus.m_valid = 1'b0;
        #1;
        check("nofwd_op1", bus.d_op1, 32'h1234);
        check("nofwd_haz", 32'(bus.d_hazzard), 32'd0);

        // Load-use hazard holds D without stall
        drive_i(1'b1, ADD, 32'h300);
        tick();
        bus.x_valid   = 1'b1;
        bus.x_is_load = 1'b1;
        bus.x_wbr     = 5'd5;
        drive_i(1'b1, JAL, 32'h304);
        #1;
        check("lu_haz", 32'(bus.d_hazzard), 32'd1);
        tick();
        check("lu_hold_instr", bus.d_instr, ADD);
        check("lu_hold_pc", bus.d_pc, 32'h300);
        check("lu_hold_valid", 32'(bus.d_valid), 32'd1);
        bus.x_valid   = 1'b0;
        bus.x_is_load = 1'b0;
        bus.m_valid   = 1'b1;
        bus.m_wbr     = 5'd5;
        bus.m_res     = 32'd7;
        #1;
`ifdef BYPASS_EN
        check("lu_m_haz", 32'(bus.d_hazzard), 32'd0);
        check("lu_m_op2", bus.d_op2, 32'd7);
`else
        check("lu_m_haz", 32'(bus.d_hazzard), 32'd1);
        check("lu_m_op2", bus.d_op2, 32'd0);
`endif
        bus.m_valid = 1'b0;
        tick();
        check("lu_release_instr", bus.d_instr, JAL);
        check("lu_release_pc", bus.d_pc, 32'h304);

        // Stall for 3 cycles while WB updates a held source
        drive_i(1'b1, ADD, 32'h400);
        tick();
        bus.stall    = 1'b1;
        bus.wb_valid = 1'b1;
        bus.wb_wbr   = 5'd4;
        bus.wb_res   = 32'h55;
        drive_i(1'b1, JAL, 32'h404);
        tick();
        check("st_byp_op1", bus.d_op1, 32'h55);
        check("st_hold_instr", bus.d_instr, ADD);
        tick();
        tick();
        check("st_hold_pc", bus.d_pc, 32'h400);
        bus.wb_valid = 1'b0;
        #1;
        check("st_refresh_op1", bus.d_op1, 32'h55);
        bus.stall = 1'b0;
        tick();
        check("st_release_instr", bus.d_instr, JAL);

        // Flush beats stall
        drive_i(1'b1, ADD, 32'h500);
        tick();
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        drive_i(1'b1, JAL, 32'h504);
        tick();
        check("fl_valid", 32'(bus.d_valid), 32'd0);
        check("fl_pc", bus.d_pc, 32'd0);
        check("fl_npc", bus.d_npc, 32'd0);
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // Flush beats a hazard
        drive_i(1'b1, ADD, 32'h508);
        tick();
        check("fh_valid", 32'(bus.d_valid), 32'd1);
        bus.x_valid   = 1'b1;
        bus.x_is_load = 1'b1;
        bus.x_wbr     = 5'd4;
        #1;
        check("fh_haz", 32'(bus.d_hazzard), 32'd1);
        bus.flush = 1'b1;
        tick();
        check("fh_flush_valid", 32'(bus.d_valid), 32'd0);
        check("fh_flush_haz", 32'(bus.d_hazzard), 32'd0);
        bus.flush = 1'b0;

        // Reset in the middle of a hazard; register file survives
        tick();
        check("rh_haz", 32'(bus.d_hazzard), 32'd1);
        rst = 1'b1;
        tick();
        check("rh_valid", 32'(bus.d_valid), 32'd0);
        check("rh_haz_after", 32'(bus.d_hazzard), 32'd0);
        check("rh_instr", bus.d_instr, 32'd0);
        check("rh_wbr", 32'(bus.d_wbr), 32'd0);
        rst = 1'b0;
        idle_fwd();
        tick();
        check("rh_reload_valid", 32'(bus.d_valid), 32'd1);
        check("rh_keep_op1", bus.d_op1, 32'h55);
        check("rh_keep_wbr", 32'(bus.d_wbr), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_d.md
Name: stage_d

Overview:
- Decode stage; sits directly downstream of the instruction fetch stage.
- Consumes i_valid/i_instr/i_pc/i_npc and extracts MIPS-I fields.
- Owns the 32x32 register file and applies operand bypassing from the X, M and WB stages.
- Detects read-after-write hazards and raises d_hazzard, which the fetch stage takes as its stall input.

Parameters:
- REGS_INIT_ZERO, 1: when 1, the register file powers up all-zero (simulation/initial block); when 0, contents are undefined until written.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  downstream stall; hold all d_* registers
- flush  in  1  kill the instruction currently in D
- i_valid  in  1  fetch output valid
- i_instr  in  32  fetched instruction
- i_pc  in  32  address of i_instr
- i_npc  in  32  i_pc+4
- x_valid  in  1  X stage holds a register-writing instruction
- x_wbr  in  5  X destination register
- x_res  in  32  X result (meaningless when x_is_load)
- x_is_load  in  1  X instruction is a load; result not yet available
- m_valid  in  1  M stage write valid
- m_wbr  in  5  M destination register
- m_res  in  32  M result
- wb_valid  in  1  write-back enable
- wb_wbr  in  5  write-back register
- wb_res  in  32  write-back data
- d_valid  out  1  decoded instruction valid
- d_instr  out  32  instruction
- d_pc  out  32  pc
- d_npc  out  32  npc
- d_opcode  out  6  instr[31:26]
- d_fn  out  6  instr[5:0]
- d_rs  out  5  instr[25:21]
- d_rt  out  5  instr[20:16]
- d_wbr  out  5  destination register, 0 = none
- d_simm  out  32  sign-extended instr[15:0]
- d_op1  out  32  bypassed rs value (combinational)
- d_op2  out  32  bypassed rt value (combinational)
- d_hazzard  out  1  RAW hazard; fetch must stall

Behaviour:
- Reset: all d_* registers are 0, d_valid = 0, d_hazzard = 0. rst overrides flush and stall. Reset does not clear the register file.
- Latency: one cycle from i_* to d_*.
- Let held = stall | d_hazzard.
- Priority: rst > flush > held > load.
  - flush: d_valid <= 0, d_pc/d_npc <= 0.
  - held: all d_* hold their values.
  - load: capture i_* and the decoded fields.
- d_wbr decode:
  - opcode 0 -> instr[15:11]
  - opcode 3 (JAL) -> 31
  - opcodes 8..15 and 32..39 -> instr[20:16]
  - otherwise 0
- Register file: synchronous read, two read ports (two RAM copies) plus one write port.
  - Read address is the rs/rt field of i_instr when loading, and d_rs/d_rt when held, so stale data is refreshed every held cycle.
  - Write occurs when wb_valid & wb_wbr != 0. Register $0 always reads 0.
- Read-during-write: the RAM returns old data. The WB bypass covers this case.
- Bypass, per operand r in {d_rs, d_rt}, first match wins:
  - r == 0 -> 0
  - x_valid & x_wbr == r -> x_res
  - m_valid & m_wbr == r -> m_res
  - wb_valid & wb_wbr == r -> wb_res
  - otherwise the registered RAM value
- d_hazzard = d_valid & (x_valid & x_is_load & x_wbr != 0 & (x_wbr == d_rs | x_wbr == d_rt)).
  - d_hazzard is combinational.
  - When flush and a hazard occur together, flush wins in the next cycle.
- A stalled D must not be lost: d_hazzard with stall = 0 still holds D. The downstream stage inserts a bubble, which is its responsibility.

Optional Feature:
- Macro BYPASS_EN.
- Defined: X/M bypass and d_hazzard exactly as above.
- Undefined: the X and M bypass terms are removed; the WB bypass and $0 rule remain. d_hazzard asserts whenever d_valid and any of x_valid or m_valid matches a nonzero d_rs/d_rt, regardless of x_is_load.

Decomposition:
- Shared package holds:
  - opcode constants (OP_SPECIAL = 0, OP_JAL = 3, ALU-imm and load/store ranges)
  - field bit-position constants
  - the 5-bit register index type
- Natural sub-module: stage_d_regfile (2R1W, $0 hardwired, holds the read-address mux).

Test Plan:
1. Reset, then i_valid = 1, i_instr = 0x00851020 (add $2,$4,$5), i_pc = 0x100 -> next cycle: d_valid = 1, d_wbr = 2, d_rs = 4, d_rt = 5, d_npc = 0x104.
2. WB writes $4 = 0x1234 one cycle before decode reads $4 -> d_op1 = 0x1234 via WB bypass; also read $0 after wb_wbr = 0 write of 0xFFFF -> 0.
3. x_valid, x_wbr = 4, x_res = 0xAAAA while m_wbr = 4, m_res = 0xBBBB -> d_op1 = 0xAAAA (X priority); without BYPASS_EN -> d_hazzard = 1.
4. Load-use: x_is_load, x_wbr = 5, D reads $5 -> d_hazzard = 1 and D holds. Next cycle x_valid = 0 and m_wbr = 5, m_res = 7 -> d_hazzard = 0, d_op2 = 7.
5. stall held 3 cycles while WB writes $4 = 0x55 then leaves -> d_op1 = 0x55 after WB deasserts, via the refreshed read.
6. flush together with stall and i_valid -> d_valid = 0 next cycle; rst mid-hazard -> d_valid = 0, d_hazzard = 0.
